vcxo_correction_slewer: RTL and testbench

- Sits directly upstream of the VCXO frequency-discipline loop and drives its signed 16-bit VCXO_correction input.
- Accepts a requested correction target from the MCU register interface and clamps it to a safe range.
- Slews the output toward the target in bounded steps at a fixed tick rate, so the discipline loop never sees a step large enough to unlock it.
- Freezes the output while transmitting.

---
 rtl/vcxo_correction_slewer.sv | 149 ++++++++++++++
 tb/tb_vcxo_correction_slewer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcxo_correction_slewer.sv
// Purpose: clamps the MCU correction target and slews VCXO_correction toward it by at most STEP_MAX per tick, frozen while tx is high.
// Latency: target is latched on the cycle after target_valid; the output moves only on slew ticks (one every TICK_DIV cycles).
// Backpressure: none, and the newest target_valid wins. Optional macro VCXO_SLEW_BYPASS_EN adds slew_bypass, which loads the target directly.
module vcxo_correction_slewer #(
    parameter int TICK_DIV   = 1228800,
    parameter int STEP_MAX   = 1,
    parameter int CORR_LIMIT = 2000
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [15:0] target_in,
    input  logic        target_valid,
    input  logic        tx,
`ifdef VCXO_SLEW_BYPASS_EN
    input  logic        slew_bypass,
`endif
    output logic [15:0] VCXO_correction,
    output logic        busy,
    output logic        at_target,
    output logic        clamped
);
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, HOLD = 2'd2} state_t;

    localparam int                 CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]      CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic signed [16:0] LIM_POS  = 17'(CORR_LIMIT);
    localparam logic signed [16:0] LIM_NEG  = -LIM_POS;
    localparam logic signed [16:0] STEP_LIM = 17'(STEP_MAX);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [15:0] target_q, target_d;
    logic signed [15:0] out_q, out_d;
    logic               clamped_q, clamped_d;
    logic               busy_q, busy_d;
    logic               at_target_q, at_target_d;

    logic               tick;
    logic signed [16:0] in_ext;
    logic signed [15:0] in_clamped;
    logic               in_oor;
    logic signed [16:0] diff, mag, step, delta;

    // Input clamp and bounded step, both in 17 bits so neither can wrap.
    always_comb begin
        in_ext     = {target_in[15], target_in};
        in_oor     = 1'b0;
        in_clamped = target_in;
        if (in_ext > LIM_POS) begin
            in_oor     = 1'b1;
            in_clamped = LIM_POS[15:0];
        end else if (in_ext < LIM_NEG) begin
            in_oor     = 1'b1;
            in_clamped = LIM_NEG[15:0];
        end

        diff  = {target_q[15], target_q} - {out_q[15], out_q};
        mag   = diff[16] ? -diff : diff;
        step  = (mag > STEP_LIM) ? STEP_LIM : mag;
        delta = diff[16] ? -step : step;
    end

    always_comb begin
        cnt_d       = cnt_q;
        state_d     = state_q;
        target_d    = target_q;
        out_d       = out_q;
        clamped_d   = clamped_q;
        tick        = 1'b0;

        if (tx) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (target_valid) begin
            target_d  = in_clamped;
            clamped_d = in_oor;
        end

        // Decisions compare against target_d so a freshly latched target is acted on without an idle cycle.
        case (state_q)
            IDLE: begin
                if (target_d != out_q) begin
                    state_d = tx ? HOLD : RAMP;
                end
            end
            RAMP: begin
                if (tx) begin
                    state_d = HOLD;
                end else begin
                    if (tick) begin
                        out_d = 16'({out_q[15], out_q} + delta);
                    end
                    if (out_d == target_d) begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!tx) begin
                    state_d = (target_d != out_q) ? RAMP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef VCXO_SLEW_BYPASS_EN
        if (slew_bypass && !tx) begin
            out_d   = target_d;
            state_d = IDLE;
            cnt_d   = '0;
        end
`endif

        busy_d      = (state_d != IDLE);
        at_target_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            target_q    <= '0;
            out_q       <= '0;
            clamped_q   <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            out_q       <= out_d;
            clamped_q   <= clamped_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
        end
    end

    assign VCXO_correction = out_q;
    assign busy            = busy_q;
    assign at_target       = at_target_q;
    assign clamped         = clamped_q;

endmodule

// File: tb/tb_vcxo_correction_slewer.sv
// Bench for vcxo_correction_slewer: per-cycle scoreboard fed by an abstract slew model, plus directed scenarios.
// Build with VCXO_SLEW_BYPASS_EN defined to also exercise slew_bypass.
module tb_vcxo_correction_slewer;
    localparam int TICK_DIV   = 4;
    localparam int STEP_MAX   = 2;
    localparam int CORR_LIMIT = 100;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic [15:0] target_in;
    logic        target_valid;
    logic        tx;
`ifdef VCXO_SLEW_BYPASS_EN
    logic        slew_bypass;
`endif
    logic [15:0] VCXO_correction;
    logic        busy;
    logic        at_target;
    logic        clamped;

    vcxo_correction_slewer #(
        .TICK_DIV  (TICK_DIV),
        .STEP_MAX  (STEP_MAX),
        .CORR_LIMIT(CORR_LIMIT)
    ) dut (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .target_in      (target_in),
        .target_valid   (target_valid),
        .tx             (tx),
`ifdef VCXO_SLEW_BYPASS_EN
        .slew_bypass    (slew_bypass),
`endif
        .VCXO_correction(VCXO_correction),
        .busy           (busy),
        .at_target      (at_target),
        .clamped        (clamped)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int out;
        bit busy;
        bit clamped;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Abstract model state: output value, latched target, tick phase, sticky flags.
    int m_out, m_tgt, m_cnt;
    bit m_busy, m_clamped;

    function automatic int clamp_lim(input int v);
        if (v > CORR_LIMIT) return CORR_LIMIT;
        if (v < -CORR_LIMIT) return -CORR_LIMIT;
        return v;
    endfunction

    task automatic model_reset();
        m_out = 0; m_tgt = 0; m_cnt = 0; m_busy = 1'b0; m_clamped = 1'b0;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one cycle at a negedge, predict the state after the next posedge, wait for the following negedge.
    task automatic step_cycle(input bit tv, input int tin, input bit txv, input bit byp);
        bit tick;
        int d, s;
        target_valid = tv;
        target_in    = 16'(tin);
        tx           = txv;
`ifdef VCXO_SLEW_BYPASS_EN
        slew_bypass  = byp;
`endif
        tick  = !txv && (m_cnt == TICK_DIV - 1);
        m_cnt = (txv || tick) ? 0 : m_cnt + 1;
        if (tick && m_out != m_tgt) begin
            d = m_tgt - m_out;
            s = (d < 0) ? -d : d;
            if (s > STEP_MAX) s = STEP_MAX;
            m_out = (d < 0) ? m_out - s : m_out + s;
        end
        if (tv) begin
            m_tgt     = clamp_lim(tin);
            m_clamped = (tin != m_tgt);
        end
`ifdef VCXO_SLEW_BYPASS_EN
        if (byp && !txv) begin
            m_out = m_tgt;
            m_cnt = 0;
        end
`endif
        // While transmitting, a pending correction keeps busy set until tx drops.
        m_busy = txv ? (m_busy || (m_out != m_tgt)) : (m_out != m_tgt);
        exp_q.push_back('{out: m_out, busy: m_busy, clamped: m_clamped});
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        repeat (n) step_cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int val, input int bound);
        int n;
        n = 0;
        while (m_out != val && n < bound) begin
            step_cycle(1'b0, 0, 1'b0, 1'b0);
            n++;
        end
        if (m_out != val) begin
            checks++;
            errors++;
            $display("FAIL run_until timeout: model output %0d, wanted %0d", m_out, val);
        end
    endtask

    task automatic do_async_reset();
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("async_reset_out", $signed(VCXO_correction), 0);
        check_val("async_reset_at_target", at_target, 1);
        check_val("async_reset_busy", busy, 0);
        @(negedge clk_in);
        target_valid = 1'b0;
        tx           = 1'b0;
        reset_n      = 1'b1;
        model_reset();
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // Monitor: one expected entry per clock while enabled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty at %0t: out=%0d with no expected entry", $time, $signed(VCXO_correction));
                end else begin
                    e = exp_q.pop_front();
                    if ($signed(VCXO_correction) != e.out || busy != e.busy || at_target != !e.busy || clamped != e.clamped) begin
                        errors++;
                        $display("FAIL cycle_check at %0t: got out=%0d busy=%0b at_target=%0b clamped=%0b, expected out=%0d busy=%0b at_target=%0b clamped=%0b",
                                 $time, $signed(VCXO_correction), busy, at_target, clamped, e.out, e.busy, !e.busy, e.clamped);
                    end
                end
            end
        end
    end

    initial begin
        bit rtx, rbyp, tv;
        int tin;
        logic signed [15:0] r16;

        reset_n = 1'b0; target_in = '0; target_valid = 1'b0; tx = 1'b0;
`ifdef VCXO_SLEW_BYPASS_EN
        slew_bypass = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        check_val("reset_out", $signed(VCXO_correction), 0);
        check_val("reset_at_target", at_target, 1);
        check_val("reset_busy", busy, 0);
        check_val("reset_clamped", clamped, 0);
        mon_en = 1'b1;
        idle(20);

        step_cycle(1'b1, 7, 1'b0, 1'b0);
        run_until(7, 50);
        check_val("ramp7_busy", busy, 0);
        idle(3);
        check_val("ramp7_out", $signed(VCXO_correction), 7);

        step_cycle(1'b1, -500, 1'b0, 1'b0);
        run_until(-100, 500);
        check_val("neg_clamp_flag", clamped, 1);
        check_val("neg_clamp_out", $signed(VCXO_correction), -100);
        step_cycle(1'b1, 10, 1'b0, 1'b0);
        idle(2);
        check_val("unclamp_flag", clamped, 0);
        run_until(10, 300);

        step_cycle(1'b1, 50, 1'b0, 1'b0);
        run_until(20, 100);
        repeat (30) step_cycle(1'b0, 0, 1'b1, 1'b0);
        check_val("tx_freeze_out", $signed(VCXO_correction), 20);
        check_val("tx_freeze_busy", busy, 1);
        run_until(50, 200);

        step_cycle(1'b1, 10, 1'b0, 1'b0);
        run_until(10, 200);
        step_cycle(1'b1, 40, 1'b0, 1'b0);
        step_cycle(1'b0, 0, 1'b0, 1'b0);
        step_cycle(1'b1, 5, 1'b0, 1'b0);
        run_until(5, 100);
        idle(5);
        check_val("retarget_out", $signed(VCXO_correction), 5);

        // Strobe in the very cycle a tick fires: that tick still heads for the old target.
        step_cycle(1'b1, 30, 1'b0, 1'b0);
        run_until(9, 100);
        for (int k = 0; k < 2 * TICK_DIV && m_cnt != TICK_DIV - 1; k++) step_cycle(1'b0, 0, 1'b0, 1'b0);
        step_cycle(1'b1, -30, 1'b0, 1'b0);
        run_until(-30, 300);

        step_cycle(1'b0, 0, 1'b1, 1'b0);
        step_cycle(1'b1, 300, 1'b1, 1'b0);
        repeat (5) step_cycle(1'b0, 0, 1'b1, 1'b0);
        check_val("tx_strobe_clamped", clamped, 1);
        check_val("tx_strobe_frozen", $signed(VCXO_correction), -30);
        run_until(100, 600);

        step_cycle(1'b1, -80, 1'b0, 1'b0);
        run_until(30, 400);
        check_val("pre_reset_busy", busy, 1);
        do_async_reset();
        idle(10);

`ifdef VCXO_SLEW_BYPASS_EN
        step_cycle(1'b1, 60, 1'b0, 1'b1);
        check_val("bypass_load", $signed(VCXO_correction), 60);
        step_cycle(1'b1, -20, 1'b1, 1'b1);
        check_val("bypass_tx_frozen", $signed(VCXO_correction), 60);
        step_cycle(1'b0, 0, 1'b0, 1'b1);
        check_val("bypass_after_tx", $signed(VCXO_correction), -20);
        idle(4);
`endif

        rtx = 1'b0;
        rbyp = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) rtx = !rtx;
            tv = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 3) == 0) begin
                r16 = 16'($urandom);
                tin = r16;
            end else begin
                tin = int'($urandom_range(0, 300)) - 150;
            end
`ifdef VCXO_SLEW_BYPASS_EN
            if ($urandom_range(0, 199) == 0) rbyp = !rbyp;
`endif
            step_cycle(tv, tin, rtx, rbyp);
        end
        idle(4);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
